// File: rtl/commit_perf_unit.sv
// Commit/performance monitor beside MEM/WB: counts cycles, retired instructions and
// cache traffic while running, then streams the frozen counters out after halt.
module commit_perf_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wb_regwrt,
  input  logic             wb_memwrt,
  input  logic             wb_halt,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [2:0]       dump_idx,
  output logic [CNT_W-1:0] dump_data,
  output logic             dump_last,
  output logic             done,
  output logic             proto_err
);

  typedef enum logic [1:0] {RUN, DUMP, FIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt     [6];
  logic [CNT_W-1:0] cntNext [6];
  logic [5:0]       incEn;
  logic             hitNoReq;
  logic [2:0]       nextIdx;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  always_comb begin
    incEn    = 6'b0;
    incEn[0] = 1'b1;
    incEn[1] = wb_halt | wb_regwrt | wb_memwrt;
    incEn[2] = icache_req;
    incEn[3] = icache_hit & icache_req;
    incEn[4] = dcache_req;
    incEn[5] = dcache_hit & dcache_req;
    for (int i = 0; i < 6; i++) cntNext[i] = satInc(cnt[i], incEn[i]);
    hitNoReq = (icache_hit & ~icache_req) | (dcache_hit & ~dcache_req);
    nextIdx  = dump_idx + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      for (int i = 0; i < 6; i++) cnt[i] <= '0;
      dump_valid <= 1'b0;
      dump_idx   <= 3'd0;
      dump_data  <= '0;
      dump_last  <= 1'b0;
      done       <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (hitNoReq) proto_err <= 1'b1;
          // Halt beats clr: the halt cycle's increments land and the dump starts
          // from the post-increment cycle count.
          if (wb_halt) begin
            for (int i = 0; i < 6; i++) cnt[i] <= cntNext[i];
            state      <= DUMP;
            dump_valid <= 1'b1;
            dump_idx   <= 3'd0;
            dump_data  <= cntNext[0];
            dump_last  <= 1'b0;
          end else if (clr) begin
            for (int i = 0; i < 6; i++) cnt[i] <= '0;
          end else begin
            for (int i = 0; i < 6; i++) cnt[i] <= cntNext[i];
          end
        end
        DUMP: begin
          if (dump_ready) begin
            if (dump_last) begin
              state      <= FIN;
              dump_valid <= 1'b0;
              dump_last  <= 1'b0;
              done       <= 1'b1;
            end else begin
              dump_idx   <= nextIdx;
              dump_data  <= cnt[nextIdx];
              dump_last  <= (nextIdx == 3'd5);
            end
          end
        end
        FIN: ;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_perf_unit.sv
// Randomised and directed bench for commit_perf_unit, running a 32-bit and a 4-bit
// instance side by side against an unbounded-integer counting model.
module tb_commit_perf_unit;

  logic clk = 1'b0;
  logic rst, clr, wb_regwrt, wb_memwrt, wb_halt;
  logic icache_req, icache_hit, dcache_req, dcache_hit, dump_ready;
  logic        dump_valid, dump_last, done, proto_err;
  logic [2:0]  dump_idx;
  logic [31:0] dump_data;
  logic        dvS, lastS, doneS, protoS;
  logic [2:0]  idxS;
  logic [3:0]  dataS;

  int checks = 0;
  int failures = 0;

  longint m [6];
  bit     mProto;
  logic [31:0] capB [6];
  logic [3:0]  capS [6];
  int capN, capErr;

  localparam longint MAXB = 64'hFFFF_FFFF;
  localparam longint MAXS = 64'd15;

  always #5 clk = ~clk;

  commit_perf_unit #(.CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .wb_regwrt(wb_regwrt), .wb_memwrt(wb_memwrt),
    .wb_halt(wb_halt), .icache_req(icache_req), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_last(dump_last), .done(done), .proto_err(proto_err)
  );

  commit_perf_unit #(.CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .clr(clr), .wb_regwrt(wb_regwrt), .wb_memwrt(wb_memwrt),
    .wb_halt(wb_halt), .icache_req(icache_req), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit), .dump_valid(dvS),
    .dump_ready(dump_ready), .dump_idx(idxS), .dump_data(dataS),
    .dump_last(lastS), .done(doneS), .proto_err(protoS)
  );

  function automatic longint satv(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zeroInputs();
    clr = 0; wb_regwrt = 0; wb_memwrt = 0; wb_halt = 0;
    icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0;
  endtask

  task automatic randInputs();
    clr = 1'($urandom_range(0, 1)); wb_regwrt = 1'($urandom_range(0, 1));
    wb_memwrt = 1'($urandom_range(0, 1)); wb_halt = 1'($urandom_range(0, 1));
    icache_req = 1'($urandom_range(0, 1)); icache_hit = 1'($urandom_range(0, 1));
    dcache_req = 1'($urandom_range(0, 1)); dcache_hit = 1'($urandom_range(0, 1));
  endtask

  task automatic doReset();
    rst = 0; zeroInputs(); dump_ready = 0;
    tick();
    rst = 1;
    for (int i = 0; i < 6; i++) m[i] = 0;
    mProto = 0;
  endtask

  // One processor cycle in RUN; the model counts from the rules, not the encoding.
  task automatic step(input bit rw, input bit mw, input bit h, input bit ir,
                      input bit ih, input bit dr, input bit dh, input bit c);
    clr = c; wb_regwrt = rw; wb_memwrt = mw; wb_halt = h;
    icache_req = ir; icache_hit = ih; dcache_req = dr; dcache_hit = dh;
    if (c && !h) begin
      for (int i = 0; i < 6; i++) m[i] = 0;
    end else begin
      m[0]++;
      if (h || rw || mw) m[1]++;
      m[2] += ir; m[3] += (ih && ir); m[4] += dr; m[5] += (dh && dr);
    end
    if ((ih && !ir) || (dh && !dr)) mProto = 1;
    tick();
    zeroInputs();
  endtask

  // Drains the dump, recording accepted words and any handshake irregularity.
  task automatic collectDump(input int mode, input bit noise);
    int idx, cyc;
    bit rdy, stalled;
    logic [31:0] prevB;
    idx = 0; cyc = 0; stalled = 0; capN = 0; capErr = 0; prevB = '0;
    while (idx < 6 && cyc < 200) begin
      if (dump_valid !== 1'b1 || dvS !== 1'b1 || dump_idx !== 3'(idx) || idxS !== 3'(idx) ||
          dump_last !== (idx == 5) || lastS !== (idx == 5) || done !== 1'b0) capErr++;
      if (stalled && dump_data !== prevB) capErr++;
      case (mode)
        0: rdy = 1;
        1: rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      dump_ready = rdy;
      if (noise) randInputs(); else zeroInputs();
      prevB = dump_data;
      if (rdy) begin capB[idx] = dump_data; capS[idx] = dataS; end
      tick();
      if (rdy) begin idx++; capN++; end
      stalled = !rdy;
      cyc++;
    end
    dump_ready = 0;
    zeroInputs();
  endtask

  task automatic test_reset();
    doReset();
    step(1, 0, 0, 0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 1, 0, 0, 0);
    dump_ready = 1;
    tick();
    rst = 0; dump_ready = 1;
    tick();
    checks++;
    if ({dump_valid, dump_idx, dump_data, dump_last, done, proto_err} !== 39'd0) begin
      failures++;
      $display("FAIL reset_outputs got v=%0b idx=%0d d=%0d l=%0b done=%0b pe=%0b want all 0",
               dump_valid, dump_idx, dump_data, dump_last, done, proto_err);
    end
    checks++;
    if ({dvS, idxS, dataS, lastS, doneS, protoS} !== 11'd0) begin
      failures++;
      $display("FAIL reset_small got v=%0b idx=%0d d=%0d want all 0", dvS, idxS, dataS);
    end
    rst = 1; dump_ready = 0;
  endtask

  task automatic test_basic();
    logic [31:0] want [6];
    want = '{32'd10, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0};
    doReset();
    for (int c = 1; c <= 10; c++) step(c inside {2, 3, 5, 7}, 0, c == 10, 0, 0, 0, 0, 0);
    collectDump(0, 0);
    checks++;
    if (capN !== 6 || capErr !== 0) begin
      failures++;
      $display("FAIL basic_handshake transfers=%0d errs=%0d want 6/0", capN, capErr);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (capB[i] !== want[i]) begin
        failures++;
        $display("FAIL basic_word%0d got %0d want %0d", i, capB[i], want[i]);
      end
    end
    // DONE must ignore further halts, clr and ready.
    for (int k = 0; k < 3; k++) begin
      wb_halt = 1; clr = 1; dump_ready = 1;
      tick();
      checks++;
      if (done !== 1'b1 || dump_valid !== 1'b0) begin
        failures++;
        $display("FAIL done_hold got done=%0b valid=%0b want 1/0", done, dump_valid);
      end
    end
    zeroInputs(); dump_ready = 0;
  endtask

  task automatic test_cache();
    doReset();
    for (int c = 0; c < 6; c++) step(0, 0, 0, 1, c < 4, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    collectDump(0, 0);
    checks++;
    if (capB[2] !== 32'd6 || capB[3] !== 32'd4 || proto_err !== 1'b0) begin
      failures++;
      $display("FAIL cache_icount got ireq=%0d ihit=%0d pe=%0b want 6/4/0", capB[2], capB[3], proto_err);
    end
    doReset();
    for (int c = 0; c < 6; c++) step(0, 0, 0, 1, c < 4, c < 3, c < 2, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    collectDump(1, 0);
    checks++;
    if (capB[4] !== 32'd3 || capB[5] !== 32'd2 || proto_err !== 1'b1) begin
      failures++;
      $display("FAIL cache_dcount got dreq=%0d dhit=%0d pe=%0b want 3/2/1", capB[4], capB[5], proto_err);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (capB[i] !== 32'(satv(m[i], MAXB))) begin
        failures++;
        $display("FAIL cache_model_word%0d got %0d want %0d", i, capB[i], m[i]);
      end
    end
  endtask

  task automatic test_stall();
    doReset();
    for (int c = 0; c < 12; c++) step(c[0], c[1], c == 11, c[2], c[0], c[1], 1, 0);
    collectDump(1, 1);
    checks++;
    if (capN !== 6 || capErr !== 0 || done !== 1'b1 || dump_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_handshake transfers=%0d errs=%0d done=%0b want 6/0/1", capN, capErr, done);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (capB[i] !== 32'(satv(m[i], MAXB))) begin
        failures++;
        $display("FAIL stall_word%0d got %0d want %0d", i, capB[i], m[i]);
      end
    end
  endtask

  task automatic test_saturate();
    doReset();
    for (int c = 1; c <= 20; c++) step(1, 0, c == 20, c > 3, 1, 1, c > 10, 0);
    collectDump(0, 0);
    checks++;
    if (capS[0] !== 4'd15 || capB[0] !== 32'd20) begin
      failures++;
      $display("FAIL sat_cyc got small=%0d big=%0d want 15/20", capS[0], capB[0]);
    end
    for (int i = 1; i < 6; i++) begin
      checks++;
      if (capS[i] !== 4'(satv(m[i], MAXS))) begin
        failures++;
        $display("FAIL sat_word%0d got %0d want %0d", i, capS[i], satv(m[i], MAXS));
      end
    end
  endtask

  task automatic test_clr();
    doReset();
    for (int c = 1; c <= 8; c++) step(1, 0, c == 8, 0, 0, 0, 0, c == 5);
    collectDump(0, 0);
    checks++;
    if (capB[0] !== 32'd3 || capB[1] !== 32'd3) begin
      failures++;
      $display("FAIL clr_mid got cyc=%0d inst=%0d want 3/3", capB[0], capB[1]);
    end
    doReset();
    for (int c = 1; c <= 5; c++) step(1, 0, c == 5, 0, 0, 0, 0, c == 5);
    collectDump(0, 0);
    checks++;
    if (capB[0] !== 32'd5 || capB[1] !== 32'd5) begin
      failures++;
      $display("FAIL clr_with_halt got cyc=%0d inst=%0d want 5/5", capB[0], capB[1]);
    end
  endtask

  task automatic test_reset_mid_dump();
    doReset();
    for (int c = 1; c <= 7; c++) step(1, 0, c == 7, 1, 1, 0, 0, 0);
    dump_ready = 1;
    tick(); tick(); tick();
    checks++;
    if (dump_idx !== 3'd3 || dump_valid !== 1'b1) begin
      failures++;
      $display("FAIL middump_idx got idx=%0d v=%0b want 3/1", dump_idx, dump_valid);
    end
    rst = 0;
    tick();
    checks++;
    if (dump_valid !== 1'b0 || dump_idx !== 3'd0 || dump_data !== 32'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL middump_reset got v=%0b idx=%0d d=%0d done=%0b want 0/0/0/0",
               dump_valid, dump_idx, dump_data, done);
    end
    rst = 1; dump_ready = 0;
    for (int i = 0; i < 6; i++) m[i] = 0;
    mProto = 0;
    for (int c = 1; c <= 4; c++) step(0, 1, c == 4, 0, 0, 1, 1, 0);
    collectDump(0, 0);
    checks++;
    if (capB[0] !== 32'd4 || capB[1] !== 32'd4 || capB[2] !== 32'd0 || capB[5] !== 32'd4) begin
      failures++;
      $display("FAIL middump_rerun got cyc=%0d inst=%0d ireq=%0d dhit=%0d want 4/4/0/4",
               capB[0], capB[1], capB[2], capB[5]);
    end
  endtask

  task automatic test_random();
    int len;
    for (int r = 0; r < 5; r++) begin
      doReset();
      len = $urandom_range(5, 45);
      for (int c = 1; c <= len; c++)
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), c == len,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 9) == 0);
      collectDump(2, 1);
      checks++;
      if (capN !== 6 || capErr !== 0 || proto_err !== mProto || protoS !== mProto) begin
        failures++;
        $display("FAIL rand%0d_proto transfers=%0d errs=%0d pe=%0b want 6/0/%0b",
                 r, capN, capErr, proto_err, mProto);
      end
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (capB[i] !== 32'(satv(m[i], MAXB)) || capS[i] !== 4'(satv(m[i], MAXS))) begin
          failures++;
          $display("FAIL rand%0d_word%0d got %0d/%0d want %0d/%0d", r, i, capB[i], capS[i],
                   satv(m[i], MAXB), satv(m[i], MAXS));
        end
      end
    end
  endtask

  initial begin
    rst = 0; dump_ready = 0; zeroInputs();
    tick();
    test_reset();
    test_basic();
    test_cache();
    test_stall();
    test_saturate();
    test_clr();
    test_reset_mid_dump();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached without finishing");
    $fatal(1);
  end

endmodule
